// File: rtl/seven_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seven_seg_scan_ctrl
//
// Time-multiplexed seven-segment display driver. Scans DIGITS hex digits, one
// slot of REFRESH_DIV clocks per digit, with all anodes held off for the first
// GUARD clocks of every slot to suppress ghosting. New display data is double
// buffered: a load lands in shadow registers and is promoted to the active set
// only at the frame wrap, so a frame never shows a mix of old and new values.
// Per-digit blanking, blinking (BLINK_FRAMES frames per half-period) and
// decimal points are supported. The display stays dark after reset until the
// first load has been promoted.
//
// Ports
//   clock         in   system clock, all state on the rising edge
//   reset         in   asynchronous active-low reset
//   digit_values  in   hex nibble per digit, digit i = [4i+3:4i]
//   dp_in         in   decimal point request per digit
//   blank_in      in   1 = digit dark
//   blink_in      in   1 = digit blinks
//   load          in   1-cycle strobe capturing digit_values and the *_in masks
//   anode         out  active-low digit enables
//   cathode       out  active-low segments, [6]=a .. [0]=g
//   dp_out        out  active-low decimal point
//   scan_index    out  digit currently addressed
//   frame_tick    out  1-cycle pulse when the scan wraps to digit 0
// -----------------------------------------------------------------------------
module seven_seg_scan_ctrl #(
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned GUARD        = 16,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [4*DIGITS-1:0]         digit_values,
    input  logic [DIGITS-1:0]           dp_in,
    input  logic [DIGITS-1:0]           blank_in,
    input  logic [DIGITS-1:0]           blink_in,
    input  logic                        load,
    output logic [DIGITS-1:0]           anode,
    output logic [6:0]                  cathode,
    output logic                        dp_out,
    output logic [$clog2(DIGITS)-1:0]   scan_index,
    output logic                        frame_tick
);

    localparam int unsigned SW = $clog2(DIGITS);
    localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] GUARD_END  = PW'(GUARD);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(DIGITS - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    // Scan timing
    logic [PW-1:0]          presc_q, presc_d;
    logic [SW-1:0]          scan_q, scan_d;
    logic                   tick_q, tick_d;
    logic [FW-1:0]          frame_cnt_q, frame_cnt_d;
    logic                   phase_q, phase_d;
    logic                   slot_end;
    logic                   wrap;

    // Shadow (load-side) buffer
    logic [4*DIGITS-1:0]    sh_val_q, sh_val_d;
    logic [DIGITS-1:0]      sh_dp_q, sh_dp_d;
    logic [DIGITS-1:0]      sh_blank_q, sh_blank_d;
    logic [DIGITS-1:0]      sh_blink_q, sh_blink_d;
    logic                   pending_q, pending_d;

    // Active (display-side) buffer
    logic [4*DIGITS-1:0]    act_val_q, act_val_d;
    logic [DIGITS-1:0]      act_dp_q, act_dp_d;
    logic [DIGITS-1:0]      act_blank_q, act_blank_d;
    logic [DIGITS-1:0]      act_blink_q, act_blink_d;
    logic                   shown_q, shown_d;

    // Registered outputs
    logic [DIGITS-1:0]      anode_q, anode_d;
    logic [6:0]             cathode_q, cathode_d;
    logic                   dp_q, dp_d;

    // Selected digit attributes
    logic [3:0]             cur_nib;
    logic                   cur_dp;
    logic                   cur_blank;
    logic                   cur_blink;
    logic                   cur_dark;

    // Standard hex decoder, active-low, [6]=a .. [0]=g
    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] s;
        unique case (nib)
            4'h0: s = 7'h01;
            4'h1: s = 7'h4F;
            4'h2: s = 7'h12;
            4'h3: s = 7'h06;
            4'h4: s = 7'h4C;
            4'h5: s = 7'h24;
            4'h6: s = 7'h20;
            4'h7: s = 7'h0F;
            4'h8: s = 7'h00;
            4'h9: s = 7'h04;
            4'hA: s = 7'h08;
            4'hB: s = 7'h60;
            4'hC: s = 7'h31;
            4'hD: s = 7'h42;
            4'hE: s = 7'h30;
            default: s = 7'h38;
        endcase
        return s;
    endfunction

    // Prescaler, scan counter and blink phase
    always_comb begin
        slot_end    = (presc_q == PRESC_LAST);
        wrap        = slot_end && (scan_q == SCAN_LAST);
        presc_d     = slot_end ? '0 : presc_q + 1'b1;
        scan_d      = scan_q;
        tick_d      = wrap;
        frame_cnt_d = frame_cnt_q;
        phase_d     = phase_q;
        if (slot_end) begin
            scan_d = wrap ? '0 : scan_q + 1'b1;
        end
        // Blink state advances on the same edge that raises frame_tick, so a
        // phase change lands together with the first slot of the new frame.
        if (wrap) begin
            if (frame_cnt_q == FRAME_LAST) begin
                frame_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    // Double buffer: load -> shadow, shadow -> active at frame wrap.
    // A load on the wrap cycle bypasses the shadow and leaves nothing pending.
    always_comb begin
        sh_val_d    = sh_val_q;
        sh_dp_d     = sh_dp_q;
        sh_blank_d  = sh_blank_q;
        sh_blink_d  = sh_blink_q;
        pending_d   = pending_q;
        act_val_d   = act_val_q;
        act_dp_d    = act_dp_q;
        act_blank_d = act_blank_q;
        act_blink_d = act_blink_q;
        shown_d     = shown_q;

        if (load) begin
            sh_val_d   = digit_values;
            sh_dp_d    = dp_in;
            sh_blank_d = blank_in;
            sh_blink_d = blink_in;
            pending_d  = 1'b1;
        end

        if (wrap) begin
            if (load) begin
                act_val_d   = digit_values;
                act_dp_d    = dp_in;
                act_blank_d = blank_in;
                act_blink_d = blink_in;
                shown_d     = 1'b1;
                pending_d   = 1'b0;
            end else if (pending_q) begin
                act_val_d   = sh_val_q;
                act_dp_d    = sh_dp_q;
                act_blank_d = sh_blank_q;
                act_blink_d = sh_blink_q;
                shown_d     = 1'b1;
                pending_d   = 1'b0;
            end
        end
    end

    // Output decode from the current (pre-edge) scan state; registering it
    // keeps anode, cathode and dp_out aligned to the same digit.
    always_comb begin
        cur_nib   = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        cur_blink = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (scan_q == SW'(i)) begin
                cur_nib   = act_val_q[4*i +: 4];
                cur_dp    = act_dp_q[i];
                cur_blank = act_blank_q[i];
                cur_blink = act_blink_q[i];
            end
        end
        cur_dark = cur_blank | (cur_blink & phase_q);

        anode_d = '1;
        if (shown_q && (presc_q >= GUARD_END)) begin
            for (int unsigned i = 0; i < DIGITS; i++) begin
                anode_d[i] = (scan_q != SW'(i));
            end
        end

        cathode_d = 7'h7F;
        dp_d      = 1'b1;
        if (shown_q && !cur_dark) begin
            cathode_d = seg7(cur_nib);
            dp_d      = ~cur_dp;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            presc_q     <= '0;
            scan_q      <= '0;
            tick_q      <= 1'b0;
            frame_cnt_q <= '0;
            phase_q     <= 1'b0;
            sh_val_q    <= '0;
            sh_dp_q     <= '0;
            sh_blank_q  <= '0;
            sh_blink_q  <= '0;
            pending_q   <= 1'b0;
            act_val_q   <= '0;
            act_dp_q    <= '0;
            act_blank_q <= '0;
            act_blink_q <= '0;
            shown_q     <= 1'b0;
            anode_q     <= '1;
            cathode_q   <= 7'h7F;
            dp_q        <= 1'b1;
        end else begin
            presc_q     <= presc_d;
            scan_q      <= scan_d;
            tick_q      <= tick_d;
            frame_cnt_q <= frame_cnt_d;
            phase_q     <= phase_d;
            sh_val_q    <= sh_val_d;
            sh_dp_q     <= sh_dp_d;
            sh_blank_q  <= sh_blank_d;
            sh_blink_q  <= sh_blink_d;
            pending_q   <= pending_d;
            act_val_q   <= act_val_d;
            act_dp_q    <= act_dp_d;
            act_blank_q <= act_blank_d;
            act_blink_q <= act_blink_d;
            shown_q     <= shown_d;
            anode_q     <= anode_d;
            cathode_q   <= cathode_d;
            dp_q        <= dp_d;
        end
    end

    assign anode      = anode_q;
    assign cathode    = cathode_q;
    assign dp_out     = dp_q;
    assign scan_index = scan_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_scan_ctrl
//
// Scoreboard bench for seven_seg_scan_ctrl (DIGITS=4, REFRESH_DIV=4, GUARD=1,
// BLINK_FRAMES=2). At each frame_tick the stimulus pushes the four expected
// digit slots of the frame; the monitor pops one entry whenever a new lit slot
// appears on anode and also checks the guard gap and slot stability.
// -----------------------------------------------------------------------------
module tb_seven_seg_scan_ctrl;

    localparam int unsigned DIGITS = 4;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic [15:0]        digit_values = '0;
    logic [3:0]         dp_in = '0;
    logic [3:0]         blank_in = '0;
    logic [3:0]         blink_in = '0;
    logic               load = 1'b0;
    logic [3:0]         anode;
    logic [6:0]         cathode;
    logic               dp_out;
    logic [1:0]         scan_index;
    logic               frame_tick;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] cath;
        logic       dp;
    } slot_t;

    slot_t       exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          frame_n = 0;
    logic [15:0] e_val = '0;
    logic [3:0]  e_dp = '0;
    logic [3:0]  e_blank = '0;
    logic [3:0]  e_blink = '0;

    seven_seg_scan_ctrl #(
        .DIGITS       (DIGITS),
        .REFRESH_DIV  (4),
        .GUARD        (1),
        .BLINK_FRAMES (2)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .digit_values (digit_values),
        .dp_in        (dp_in),
        .blank_in     (blank_in),
        .blink_in     (blink_in),
        .load         (load),
        .anode        (anode),
        .cathode      (cathode),
        .dp_out       (dp_out),
        .scan_index   (scan_index),
        .frame_tick   (frame_tick)
    );

    always #5 clock = ~clock;

    function automatic logic [6:0] seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h01;  4'h1: s = 7'h4F;  4'h2: s = 7'h12;  4'h3: s = 7'h06;
            4'h4: s = 7'h4C;  4'h5: s = 7'h24;  4'h6: s = 7'h20;  4'h7: s = 7'h0F;
            4'h8: s = 7'h00;  4'h9: s = 7'h04;  4'hA: s = 7'h08;  4'hB: s = 7'h60;
            4'hC: s = 7'h31;  4'hD: s = 7'h42;  4'hE: s = 7'h30;  default: s = 7'h38;
        endcase
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Push the four expected slots of the frame that starts now.
    task automatic start_frame();
        slot_t      s;
        logic       dark;
        logic       ph;
        logic [3:0] nib;
        chk("slots_consumed", 32'(exp_q.size()), 32'd0);
        ph = (((frame_n / 2) % 2) == 1);
        for (int i = 0; i < 4; i++) begin
            nib    = e_val[4*i +: 4];
            dark   = e_blank[i] | (e_blink[i] & ph);
            s.an   = 4'hF;
            s.an[i] = 1'b0;
            s.cath = dark ? 7'h7F : seg(nib);
            s.dp   = dark ? 1'b1 : ~e_dp[i];
            exp_q.push_back(s);
        end
    endtask

    task automatic wait_tick();
        bit got;
        got = 0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clock);
            if (frame_tick) got = 1;
        end
        if (got) begin
            frame_n++;
        end else begin
            checks++;
            errors++;
            $display("FAIL tick_timeout actual=none required=frame_tick within 40 cycles");
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d,
                           input logic [3:0] bl, input logic [3:0] bk);
        digit_values = v;
        dp_in        = d;
        blank_in     = bl;
        blink_in     = bk;
        load         = 1'b1;
        @(negedge clock);
        load         = 1'b0;
    endtask

    // Monitor: a lit slot begins when anode leaves 4'hF.
    initial begin : monitor
        logic [3:0] prev_an;
        logic [6:0] slot_cath;
        int         f_run;
        bit         lit_seen;
        slot_t      s;
        prev_an   = 4'hF;
        slot_cath = 7'h7F;
        f_run     = 0;
        lit_seen  = 0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                lit_seen = 0;
                f_run    = 0;
            end else if (anode == 4'hF) begin
                f_run++;
            end else if (prev_an == 4'hF) begin
                if (lit_seen) chk("guard_len", 32'(f_run), 32'd1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_slot anode=%h cathode=%h required=no lit digit t=%0t",
                             anode, cathode, $time);
                end else begin
                    s = exp_q.pop_front();
                    chk("slot_anode", 32'(anode), 32'(s.an));
                    chk("slot_cathode", 32'(cathode), 32'(s.cath));
                    chk("slot_dp", 32'(dp_out), 32'(s.dp));
                end
                lit_seen  = 1;
                f_run     = 0;
                slot_cath = cathode;
            end else begin
                chk("slot_stable", 32'({anode, cathode}), 32'({prev_an, slot_cath}));
            end
            prev_an = anode;
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        // Reset values
        repeat (3) @(negedge clock);
        chk("rst_anode", 32'(anode), 32'hF);
        chk("rst_cathode", 32'(cathode), 32'h7F);
        chk("rst_dp", 32'(dp_out), 32'd1);
        chk("rst_scan", 32'(scan_index), 32'd0);
        chk("rst_tick", 32'(frame_tick), 32'd0);
        reset = 1'b1;

        // Scan cadence with no data loaded: display dark
        for (int k = 0; k <= 20; k++) begin
            chk("scan_seq", 32'(scan_index), 32'((k / 4) % 4));
            chk("tick_seq", 32'(frame_tick), 32'(k == 16));
            chk("dark_anode", 32'(anode), 32'hF);
            if (k < 20) @(negedge clock);
        end
        frame_n = 1;

        // Mid-frame load waits for the next frame
        do_load(16'h1234, 4'b0000, 4'b0000, 4'b0000);
        repeat (4) @(negedge clock);
        chk("pre_tick_cathode", 32'(cathode), 32'h7F);
        chk("pre_tick_anode", 32'(anode), 32'hF);
        wait_tick();
        chk("scan_at_tick", 32'(scan_index), 32'd0);
        e_val = 16'h1234; e_dp = '0; e_blank = '0; e_blink = '0;
        start_frame();
        wait_tick();
        start_frame();

        // Blink digit0, blank digit1, decimal point on digit2
        @(negedge clock);
        do_load(16'h1234, 4'b0100, 4'b0010, 4'b0001);
        wait_tick();
        e_dp = 4'b0100; e_blank = 4'b0010; e_blink = 4'b0001;
        start_frame();
        for (int f = 0; f < 4; f++) begin
            wait_tick();
            start_frame();
        end

        // Load on the exact wrap cycle bypasses the shadow
        repeat (15) @(negedge clock);
        digit_values = 16'hFFFF; dp_in = '0; blank_in = '0; blink_in = '0;
        load = 1'b1;
        @(negedge clock);
        load = 1'b0;
        chk("bypass_tick", 32'(frame_tick), 32'd1);
        frame_n++;
        e_val = 16'hFFFF; e_dp = '0; e_blank = '0; e_blink = '0;
        start_frame();

        // Two loads in one frame: last wins
        repeat (3) @(negedge clock);
        do_load(16'hAAAA, 4'b0000, 4'b0000, 4'b0000);
        @(negedge clock);
        do_load(16'h5555, 4'b0000, 4'b0000, 4'b0000);
        wait_tick();
        e_val = 16'h5555;
        start_frame();
        wait_tick();
        start_frame();

        // Reset mid-slot with a pending load
        repeat (5) @(negedge clock);
        do_load(16'h0F0F, 4'b1111, 4'b0000, 4'b0000);
        @(negedge clock);
        chk("pre_reset_lit", 32'(anode == 4'hF), 32'd0);
        #2 reset = 1'b0;
        #1;
        chk("async_anode", 32'(anode), 32'hF);
        chk("async_cathode", 32'(cathode), 32'h7F);
        chk("async_dp", 32'(dp_out), 32'd1);
        chk("async_scan", 32'(scan_index), 32'd0);
        chk("async_tick", 32'(frame_tick), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clock);
        reset = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clock);
            if (n % 8 == 7) begin
                chk("post_rst_anode", 32'(anode), 32'hF);
                chk("post_rst_cathode", 32'(cathode), 32'h7F);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
